// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution datapath: saturation bounds,
// accumulator state encoding and the signed-add overflow helper.
package cnn_pkg;

  localparam int PSUM_WIDTH = 32;
  localparam logic [PSUM_WIDTH-1:0] SAT_MAX = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
  localparam logic [PSUM_WIDTH-1:0] SAT_MIN = {1'b1, {(PSUM_WIDTH-1){1'b0}}};

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Two's complement overflow: operands agree in sign, result does not.
  function automatic logic sat_add_ovf(input logic a, input logic b, input logic s);
    return (a == b) && (s != a);
  endfunction

endpackage

// File: rtl/adder.sv
// Plain ripple-carry adder; the carry chain is walked bit by bit.
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  logic carry;

  always_comb begin
    s     = {WIDTH{1'b0}};
    carry = cin;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/conv_psum_accumulator.sv
// Sums KERNEL_LEN signed products onto a per-window bias with saturation,
// then holds the window result until the downstream stage accepts it.
import cnn_pkg::*;

module conv_psum_accumulator #(
  parameter int DATA_WIDTH = PSUM_WIDTH,
  parameter int KERNEL_LEN = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] bias,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_ovf
);

  localparam int CW = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(KERNEL_LEN - 1);
  localparam logic [DATA_WIDTH-1:0] SAT_HI = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_LO = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam int MSB = DATA_WIDTH - 1;

  state_t                state;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] acc;
  logic                  ovf;

  logic [DATA_WIDTH-1:0] base;
  logic [DATA_WIDTH-1:0] sum_raw;
  logic [DATA_WIDTH-1:0] sum_sat;
  logic                  add_ovf;
  logic                  win_ovf;
  logic                  adder_co_unused;

  // The first product of a window starts from the bias instead of the accumulator.
  always_comb begin
    base = acc;
    if (count == {CW{1'b0}}) begin
      base = bias;
    end else begin
      base = acc;
    end
  end

  adder #(.WIDTH(DATA_WIDTH)) u_adder (
    .a   (base),
    .b   (in_data),
    .cin (1'b0),
    .s   (sum_raw),
    .co  (adder_co_unused)
  );

  // Clamp on overflow; the product sign tells which rail was crossed.
  always_comb begin
    add_ovf = sat_add_ovf(base[MSB], in_data[MSB], sum_raw[MSB]);
    sum_sat = sum_raw;
    if (add_ovf) begin
      sum_sat = in_data[MSB] ? SAT_LO : SAT_HI;
    end else begin
      sum_sat = sum_raw;
    end
    win_ovf = add_ovf | ((count != {CW{1'b0}}) & ovf);
  end

  // Window sequencing, accumulation and the registered output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      count     <= {CW{1'b0}};
      acc       <= {DATA_WIDTH{1'b0}};
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= {DATA_WIDTH{1'b0}};
      out_ovf   <= 1'b0;
      in_ready  <= 1'b1;
    end else if (clear) begin
      state     <= ACC;
      count     <= {CW{1'b0}};
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            if (count == LAST) begin
              out_data  <= sum_sat;
              out_ovf   <= win_ovf;
              count     <= {CW{1'b0}};
              state     <= HOLD;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
            end else begin
              acc   <= sum_sat;
              ovf   <= win_ovf;
              count <= count + {{(CW-1){1'b0}}, 1'b1};
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACC;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ACC;
          count     <= {CW{1'b0}};
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_psum_accumulator.sv
// Bench: four accumulators (K=9,3,2,4) against an integer-arithmetic window
// model checked every cycle, plus literal expectations per scenario.
module tb_conv_psum_accumulator;
  import cnn_pkg::*;

  localparam int NI = 4;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  int kl [NI] = '{9, 3, 2, 4};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear     [NI];
  logic [31:0] bias      [NI];
  logic        in_valid  [NI];
  logic        in_ready  [NI];
  logic [31:0] in_data   [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
  logic [31:0] out_data  [NI];
  logic        out_ovf   [NI];

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  conv_psum_accumulator #(.DATA_WIDTH(32), .KERNEL_LEN(9)) u_k9 (
    .clk(clk), .rst_n(rst_n), .clear(clear[0]), .bias(bias[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .in_data(in_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .out_ovf(out_ovf[0]));
  conv_psum_accumulator #(.DATA_WIDTH(32), .KERNEL_LEN(3)) u_k3 (
    .clk(clk), .rst_n(rst_n), .clear(clear[1]), .bias(bias[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .in_data(in_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .out_ovf(out_ovf[1]));
  conv_psum_accumulator #(.DATA_WIDTH(32), .KERNEL_LEN(2)) u_k2 (
    .clk(clk), .rst_n(rst_n), .clear(clear[2]), .bias(bias[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .in_data(in_data[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]), .out_ovf(out_ovf[2]));
  conv_psum_accumulator #(.DATA_WIDTH(32), .KERNEL_LEN(4)) u_k4 (
    .clk(clk), .rst_n(rst_n), .clear(clear[3]), .bias(bias[3]), .in_valid(in_valid[3]),
    .in_ready(in_ready[3]), .in_data(in_data[3]), .out_valid(out_valid[3]),
    .out_ready(out_ready[3]), .out_data(out_data[3]), .out_ovf(out_ovf[3]));

  // Window model: products are summed as wide integers and clamped after each add.
  bit          m_hold [NI] = '{default: 1'b0};
  int          m_cnt  [NI] = '{default: 0};
  longint      m_acc  [NI] = '{default: 0};
  bit          m_ovf  [NI] = '{default: 1'b0};
  bit          m_oovf [NI] = '{default: 1'b0};
  logic [31:0] m_out  [NI] = '{default: 32'h0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_hold[i] = 1'b0; m_cnt[i] = 0; m_acc[i] = 0;
        m_ovf[i] = 1'b0; m_oovf[i] = 1'b0; m_out[i] = 32'h0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (clear[i]) begin
          m_hold[i] = 1'b0; m_cnt[i] = 0; m_ovf[i] = 1'b0;
        end else if (m_hold[i]) begin
          if (out_ready[i]) m_hold[i] = 1'b0;
        end else if (in_valid[i]) begin
          longint s;
          bit     o;
          if (m_cnt[i] == 0) begin
            s = longint'($signed(bias[i])) + longint'($signed(in_data[i]));
            m_ovf[i] = 1'b0;
          end else begin
            s = m_acc[i] + longint'($signed(in_data[i]));
          end
          o = (s > MAXV) || (s < MINV);
          if (s > MAXV) s = MAXV;
          if (s < MINV) s = MINV;
          m_ovf[i] = m_ovf[i] | o;
          if (m_cnt[i] == kl[i] - 1) begin
            m_out[i] = s[31:0]; m_oovf[i] = m_ovf[i]; m_hold[i] = 1'b1; m_cnt[i] = 0;
          end else begin
            m_acc[i] = s; m_cnt[i] = m_cnt[i] + 1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle compare: handshake flags always, result fields while a result is held.
  always begin
    @(posedge clk);
    #2;
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("in_ready[%0d]", i), {31'h0, in_ready[i]}, {31'h0, !m_hold[i]});
        chk($sformatf("out_valid[%0d]", i), {31'h0, out_valid[i]}, {31'h0, m_hold[i]});
        if (m_hold[i]) begin
          chk($sformatf("out_data[%0d]", i), out_data[i], m_out[i]);
          chk($sformatf("out_ovf[%0d]", i), {31'h0, out_ovf[i]}, {31'h0, m_oovf[i]});
        end
      end
    end
  end

  task automatic push(input int i, input logic [31:0] b, input logic [31:0] d);
    @(negedge clk);
    in_valid[i] = 1'b1; bias[i] = b; in_data[i] = d;
  endtask

  task automatic idle(input int i);
    @(negedge clk);
    in_valid[i] = 1'b0;
  endtask

  // Checks the result one cycle after the final product edge, against literals.
  task automatic expect_result(input int i, input string name, input logic [31:0] d, input logic o);
    @(posedge clk);
    #2;
    chk({name, "_valid"}, {31'h0, out_valid[i]}, 32'h1);
    chk({name, "_data"}, out_data[i], d);
    chk({name, "_ovf"}, {31'h0, out_ovf[i]}, {31'h0, o});
    chk({name, "_model"}, m_out[i], d);
  endtask

  task automatic check_reset_values(input int i, input string name);
    chk({name, "_rst_valid"}, {31'h0, out_valid[i]}, 32'h0);
    chk({name, "_rst_ready"}, {31'h0, in_ready[i]}, 32'h1);
    chk({name, "_rst_data"}, out_data[i], 32'h0);
    chk({name, "_rst_ovf"}, {31'h0, out_ovf[i]}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      clear[i] = 1'b0; bias[i] = 32'h0; in_valid[i] = 1'b0;
      in_data[i] = 32'h0; out_ready[i] = 1'b1;
    end
    #12;
    for (int i = 0; i < NI; i++) check_reset_values(i, $sformatf("init%0d", i));
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // K=9: bias 10 plus 1..9 gives 55, valid for exactly one cycle.
    for (int k = 1; k <= 9; k++) push(0, 32'd10, 32'(k));
    expect_result(0, "k9_sum", 32'd55, 1'b0);
    idle(0);
    @(posedge clk); #2;
    chk("k9_valid_drop", {31'h0, out_valid[0]}, 32'h0);

    // K=3: positive saturation, then a -1 pulls back off the rail.
    push(1, 32'h7FFF_FFF0, 32'h0000_0010);
    push(1, 32'h0,         32'h0000_0010);
    push(1, 32'h0,         32'hFFFF_FFFF);
    expect_result(1, "k3_sat", 32'h7FFF_FFFE, 1'b1);
    idle(1);

    // K=2: negative saturation, then a clean window clears the flag.
    push(2, 32'h8000_0000, 32'hFFFF_FFFF);
    push(2, 32'h0,         32'hFFFF_FFFF);
    expect_result(2, "k2_negsat", SAT_MIN, 1'b1);
    idle(2);
    push(2, 32'h0, 32'd2);
    push(2, 32'h0, 32'd3);
    expect_result(2, "k2_clean", 32'd5, 1'b0);
    idle(2);

    // K=3: downstream stall for 5 cycles while upstream keeps offering data.
    @(negedge clk);
    out_ready[1] = 1'b0;
    push(1, 32'h0, 32'd1);
    push(1, 32'h0, 32'd2);
    push(1, 32'h0, 32'd3);
    expect_result(1, "k3_stall", 32'd6, 1'b0);
    @(negedge clk);
    in_data[1] = 32'd100;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #2;
      chk("k3_stall_ready", {31'h0, in_ready[1]}, 32'h0);
      chk("k3_stall_data", out_data[1], 32'd6);
    end
    @(negedge clk);
    out_ready[1] = 1'b1; in_valid[1] = 1'b0;
    @(posedge clk); #2;
    chk("k3_release_ready", {31'h0, in_ready[1]}, 32'h1);
    chk("k3_release_valid", {31'h0, out_valid[1]}, 32'h0);

    // K=4: abort after two products, then a full window of ones.
    push(3, 32'h0, 32'd5);
    push(3, 32'h0, 32'd6);
    @(negedge clk);
    in_valid[3] = 1'b0; clear[3] = 1'b1;
    @(negedge clk);
    clear[3] = 1'b0;
    for (int k = 0; k < 4; k++) push(3, 32'h0, 32'd1);
    expect_result(3, "k4_after_clear", 32'd4, 1'b0);
    idle(3);

    // K=4: async reset mid-window, then in HOLD.
    push(3, 32'd7, 32'd1);
    push(3, 32'd7, 32'd2);
    idle(3);
    #1 rst_n = 1'b0;
    #1 check_reset_values(3, "k4_midwin");
    @(negedge clk);
    rst_n = 1'b1;
    push(3, 32'h0, 32'd1);
    push(3, 32'h0, 32'd2);
    push(3, 32'h0, 32'd3);
    push(3, 32'h0, 32'd4);
    out_ready[3] = 1'b0;
    expect_result(3, "k4_post_rst", 32'd10, 1'b0);
    idle(3);
    #1 rst_n = 1'b0;
    #1 check_reset_values(3, "k4_hold");
    @(negedge clk);
    rst_n = 1'b1; out_ready[3] = 1'b1;
    for (int k = 0; k < 4; k++) push(3, 32'd1, 32'd1);
    expect_result(3, "k4_final", 32'd5, 1'b0);
    idle(3);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
